lsu_mem_ctrl: RTL and testbench

- Load/store controller that acts as initiator toward the single-port synchronous data memory (word-indexed, 1024 x 32, one-cycle registered read, write on clock edge when enabled).
- Accepts byte, half and word load/store requests from the CPU datapath via a valid/ready handshake, drives the memory's address, data, write-enable and read-enable, and returns load data or store completion on a response handshake.
- Sub-word stores are done as read-modify-write, because the memory only writes full words.

---
 rtl/lsu_mem_ctrl_if.sv | 65 ++++++
 rtl/lsu_mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl_if
//
// Bundles the CPU request/response handshake and the data-memory bus of the
// load/store controller.
//
// Signals
//   req_valid/req_ready      CPU request handshake
//   req_write                1 = store, 0 = load
//   req_size                 00 byte, 01 half, 10 word, 11 reserved
//   req_signed               load sign-extension select
//   req_addr [AW-1:0]        byte address
//   req_wdata[31:0]          store data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata[31:0]          extended load data (0 for stores/errors)
//   rsp_err                  request rejected
//   mem_addr [AW-1:0]        memory word index
//   mem_wdata[31:0]          memory write word
//   mem_we / mem_re          memory write / read enables
//   mem_rdata[31:0]          memory read data (valid the cycle after mem_re)
//
// Modports
//   slave  : the controller (accepts CPU requests, drives the memory bus)
//   master : the CPU plus memory environment around the controller
// ---------------------------------------------------------------------------
interface lsu_mem_ctrl_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store controller between the CPU datapath and a single-port,
// word-indexed synchronous data memory (one-cycle registered read, write on
// the clock edge). Byte and half stores are performed as read-modify-write
// because the memory only writes whole words.
//
// Ports
//   clk    : clock, all state updates on posedge
//   rst_n  : synchronous active-low reset
//   bus    : lsu_mem_ctrl_if.slave (CPU request/response + memory bus)
//
// Parameters
//   MEM_WORDS : memory depth in 32-bit words (legal bytes 0..MEM_WORDS*4-1)
//   AW        : width of the CPU byte address and of mem_addr
//
// Configuration
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses are
//                          rejected with rsp_err; otherwise they are
//                          force-aligned by ignoring the low address bits.
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        RSP
    } state_t;

    localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(MEM_WORDS * 4);

    state_t        state_q;
    logic          write_q;
    logic [1:0]    size_q;
    logic          signed_q;
    logic [AW-1:0] addr_q;
    // Only the low half of the store data is ever merged; word stores go
    // straight into wbuf_q at accept time.
    logic [15:0]   wdata_q;
    logic [31:0]   wbuf_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;

    logic          misalign_d;
    logic          req_err_d;
    logic [7:0]    lane8_d;
    logic [15:0]   lane16_d;
    logic [31:0]   load_ext_d;
    logic [31:0]   merge_d;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_d = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign_d = 1'b0;
`endif

    // Zero-extend before comparing so a limit equal to 2**AW still works.
    assign req_err_d = ({1'b0, bus.req_addr} >= ADDR_LIMIT) ||
                       (bus.req_size == 2'b11) || misalign_d;

    // Lane extraction for loads and lane merge for sub-word stores, both
    // working on the word returned by the memory in RD_WAIT (little-endian).
    always_comb begin
        lane8_d    = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane16_d   = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        load_ext_d = bus.mem_rdata;
        merge_d    = bus.mem_rdata;
        case (size_q)
            2'b00: begin
                load_ext_d = {{24{signed_q & lane8_d[7]}}, lane8_d};
                merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_ext_d = {{16{signed_q & lane16_d[15]}}, lane16_d};
                merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q;
            end
            default: begin
                load_ext_d = bus.mem_rdata;
            end
        endcase
    end

    // Main controller FSM; every response output is a register written on
    // the transition into RSP so it stays stable until rsp_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 16'h0;
            wbuf_q      <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q  <= bus.req_write;
                        size_q   <= bus.req_size;
                        signed_q <= bus.req_signed;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata[15:0];
                        if (req_err_d) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                            state_q     <= RSP;
                        end else if (!bus.req_write) begin
                            state_q <= RD;
                        end else if (bus.req_size == 2'b10) begin
                            wbuf_q  <= bus.req_wdata;
                            state_q <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (write_q) begin
                        wbuf_q  <= merge_d;
                        state_q <= WR;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= load_ext_d;
                        state_q     <= RSP;
                    end
                end
                WR: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    state_q     <= RSP;
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Enables are gated with rst_n so a reset landing in WR cannot let a
    // partially built word reach the memory.
    assign bus.mem_re    = (state_q == RD) && rst_n;
    assign bus.mem_we    = (state_q == WR) && rst_n;
    assign bus.mem_addr  = {2'b00, addr_q[AW-1:2]};
    assign bus.mem_wdata = wbuf_q;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//
// Directed testbench for lsu_mem_ctrl with a behavioural 1024 x 32 memory.
// Each request pushes its expected response into a queue; a monitor on the
// falling edge pops it when the response appears and checks data, error,
// latency and the memory accesses seen since the previous response.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          cycle;
        int          nRe;
        int          nWe;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    lsu_mem_ctrl_if #(.AW(32)) bus ();

    lsu_mem_ctrl #(
        .MEM_WORDS (1024),
        .AW        (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nMiss = 0;
    int cycleCnt = 0;
    int doneCnt = 0;
    int vecId = 0;

    exp_t expQ[$];
    exp_t cur;
    logic haveCur = 1'b0;
    logic inResp = 1'b0;
    int reCnt = 0;
    int weCnt = 0;
    logic [31:0] reAddr = 32'h0;
    logic [31:0] weAddr = 32'h0;
    logic [31:0] weData = 32'h0;

    // Behavioural data memory with a side port for preloading.
    logic [31:0] mem [0:1023];
    logic        preWe = 1'b0;
    logic [9:0]  preAddr = 10'h0;
    logic [31:0] preData = 32'h0;

    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (preWe) mem[preAddr] <= preData;
        if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[9:0]];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: memory-bus accounting and response checking.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("memEnDuringReset", {30'h0, bus.mem_we, bus.mem_re}, 32'h0);
            inResp = 1'b0;
            reCnt  = 0;
            weCnt  = 0;
        end else begin
            if (bus.mem_re && bus.mem_we) checkOutput("memReWeTogether", 32'h1, 32'h0);
            if (bus.mem_re) begin
                reCnt++;
                reAddr = bus.mem_addr;
            end
            if (bus.mem_we) begin
                weCnt++;
                weAddr = bus.mem_addr;
                weData = bus.mem_wdata;
            end
            if (bus.rsp_valid) begin
                if (!inResp) begin
                    if (expQ.size() == 0) begin
                        haveCur = 1'b0;
                        checkOutput("unexpectedRsp", 32'h1, 32'h0);
                    end else begin
                        cur = expQ.pop_front();
                        haveCur = 1'b1;
                        checkOutput($sformatf("v%0d_latency", cur.id), cycleCnt, cur.cycle);
                        checkOutput($sformatf("v%0d_reCount", cur.id), reCnt, cur.nRe);
                        checkOutput($sformatf("v%0d_weCount", cur.id), weCnt, cur.nWe);
                        if (cur.nRe > 0) checkOutput($sformatf("v%0d_reAddr", cur.id), reAddr, cur.addr);
                        if (cur.nWe > 0) begin
                            checkOutput($sformatf("v%0d_weAddr", cur.id), weAddr, cur.addr);
                            checkOutput($sformatf("v%0d_weData", cur.id), weData, cur.wdata);
                        end
                    end
                    reCnt  = 0;
                    weCnt  = 0;
                    inResp = 1'b1;
                end
                if (haveCur) begin
                    checkOutput($sformatf("v%0d_rdata", cur.id), bus.rsp_rdata, cur.rdata);
                    checkOutput($sformatf("v%0d_err", cur.id), {31'h0, bus.rsp_err}, {31'h0, cur.err});
                    checkOutput($sformatf("v%0d_reqReadyInRsp", cur.id), {31'h0, bus.req_ready}, 32'h0);
                end
                if (bus.rsp_ready) begin
                    inResp = 1'b0;
                    doneCnt++;
                end
            end else if (inResp) begin
                inResp = 1'b0;
                checkOutput("rspValidDropped", 32'h1, 32'h0);
            end
        end
    end

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        preWe   = 1'b1;
        preAddr = idx;
        preData = val;
        @(posedge clk); #1;
        preWe = 1'b0;
    endtask

    task automatic waitIdle(input string name, output bit ok);
        int waitCnt;
        waitCnt = 0;
        while (!bus.req_ready && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        ok = bus.req_ready;
        if (!ok) checkOutput({name, "_reqReadyTimeout"}, 32'h0, 32'h1);
    endtask

    // Issue one request, queue its expected response and wait for the
    // response handshake (optionally withholding rsp_ready for 'hold' cycles).
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr, input int lat,
                                 input int nRe, input int nWe, input logic [31:0] expWdata,
                                 input int hold);
        exp_t e;
        int waitCnt;
        int target;
        bit ok;
        string name;
        vecId++;
        name = $sformatf("v%0d", vecId);
        waitIdle(name, ok);
        if (!ok) return;
        bus.rsp_ready  = (hold == 0);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        e.id    = vecId;
        e.rdata = expRdata;
        e.err   = expErr;
        e.cycle = cycleCnt + lat;
        e.nRe   = nRe;
        e.nWe   = nWe;
        e.addr  = addr >> 2;
        e.wdata = expWdata;
        expQ.push_back(e);
        target = doneCnt + 1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (hold > 0) begin
            waitCnt = 0;
            while (!bus.rsp_valid && waitCnt < 20) begin
                @(posedge clk); #1;
                waitCnt++;
            end
            repeat (hold) begin
                @(posedge clk); #1;
            end
            bus.rsp_ready = 1'b1;
        end
        waitCnt = 0;
        while (doneCnt < target && waitCnt < 40) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput({name, "_rspHandshake"}, 32'(doneCnt >= target), 32'h1);
    endtask

    // Start a sub-word store, pull reset after 'resetAt' further edges
    // (1 = in RD_WAIT, 2 = in WR) and confirm the word is untouched.
    task automatic applyResetRmw(input logic [31:0] addr, input logic [31:0] wdata,
                                 input int resetAt, input logic [9:0] idx,
                                 input logic [31:0] expWord);
        bit ok;
        vecId++;
        waitIdle($sformatf("v%0d", vecId), ok);
        if (!ok) return;
        bus.rsp_ready  = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (resetAt) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput($sformatf("v%0d_wordAfterReset", vecId), mem[idx], expWord);
        checkOutput($sformatf("v%0d_reqReadyAfterReset", vecId), {31'h0, bus.req_ready}, 32'h1);
        checkOutput($sformatf("v%0d_rspValidAfterReset", vecId), {31'h0, bus.rsp_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b1;
        @(posedge clk); #1;
        preload(10'd4,    32'h11223344);
        preload(10'd5,    32'h8899AABB);
        preload(10'd1023, 32'hA5000000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        checkOutput("resetReqReady", {31'h0, bus.req_ready}, 32'h1);
        checkOutput("resetRspValid", {31'h0, bus.rsp_valid}, 32'h0);
        checkOutput("resetRspRdata", bus.rsp_rdata, 32'h0);
        checkOutput("resetRspErr",   {31'h0, bus.rsp_err}, 32'h0);
        checkOutput("resetMemEn",    {30'h0, bus.mem_we, bus.mem_re}, 32'h0);

        //            wr    size   sg    addr          wdata         expRdata      err  lat re we expWdata     hold
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h14,       32'h0,        32'h8899AABB, 1'b0, 3, 1, 0, 32'h0,        0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h17,       32'h0,        32'hFFFFFF88, 1'b0, 3, 1, 0, 32'h0,        0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h14,       32'h0,        32'h0000AABB, 1'b0, 3, 1, 0, 32'h0,        0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h16,       32'h0,        32'hFFFF8899, 1'b0, 3, 1, 0, 32'h0,        0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h15,       32'h0,        32'h000000AA, 1'b0, 3, 1, 0, 32'h0,        0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h15,       32'h0000005A, 32'h0,        1'b0, 4, 1, 1, 32'h88995ABB, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h14,       32'h0,        32'h88995ABB, 1'b0, 3, 1, 0, 32'h0,        0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h16,       32'h1234CAFE, 32'h0,        1'b0, 4, 1, 1, 32'hCAFE5ABB, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h20,       32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h20,       32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0, 32'h0,        0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h1000,     32'h12345678, 32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'hFFF,      32'h0,        32'hFFFFFFA5, 1'b0, 3, 1, 0, 32'h0,        0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h14,       32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h13,       32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
`else
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h13,       32'h0,        32'h00001122, 1'b0, 3, 1, 0, 32'h0,        0);
`endif
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h14,       32'h0,        32'hCAFE5ABB, 1'b0, 3, 1, 0, 32'h0,        5);

        applyResetRmw(32'h14, 32'h000000FF, 2, 10'd5, 32'hCAFE5ABB);
        applyResetRmw(32'h15, 32'h00000011, 1, 10'd5, 32'hCAFE5ABB);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h14,       32'h0,        32'hCAFE5ABB, 1'b0, 3, 1, 0, 32'h0,        0);

        repeat (3) @(posedge clk);
        checkOutput("scoreboardEmpty", expQ.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
